// File: rtl/wb_pkg.sv
// Shared defaults and encodings for the write-back stage.
// No logic: constants, source indices and the head/skid occupancy encoding.
// No flow control of its own.
package wb_pkg;

  localparam int WB_DATA_W = 16;
  localparam int WB_ADDR_W = 3;
  localparam int WB_N_SRC  = 4;

  // Conventional meaning of each write-back source slot.
  localparam int WB_SRC_ALU  = 0;
  localparam int WB_SRC_MEM  = 1;
  localparam int WB_SRC_IMM  = 2;
  localparam int WB_SRC_PORT = 3;

  // Occupancy as {head_v, skid_v}; 2'b01 cannot occur.
  typedef enum logic [1:0] {
    WB_EMPTY = 2'b00,
    WB_ONE   = 2'b10,
    WB_TWO   = 2'b11
  } wb_state_e;

endpackage

// File: rtl/wb_src_mux.sv
// Selects one of N_SRC packed write-back sources; out-of-range selector gives zero.
// Latency: combinational.
// Backpressure: none, pure datapath.
module wb_src_mux #(
  parameter int N_SRC  = 4,
  parameter int DATA_W = 16,
  localparam int SEL_W = $clog2(N_SRC)
) (
  input  logic [N_SRC*DATA_W-1:0] src_dat,
  input  logic [SEL_W-1:0]        sel,
  output logic [DATA_W-1:0]       wb_dat
);

  // Priority-free one-hot match; no match (selector >= N_SRC) leaves zero.
  always_comb begin
    wb_dat = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (int'(sel) == k) begin
        wb_dat = src_dat[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/wb_stage_skid_buffer.sv
// EX/MEM->WB register with a 2-entry skid, flush, write-back mux and forwarding tap.
// Latency: 1 cycle from accept to head outputs; 1 entry/cycle while i_ready is high.
// Backpressure: o_ready = !skid_v, purely registered; second entry lands in skid, never dropped.
module wb_stage_skid_buffer
  import wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int N_SRC  = WB_N_SRC,
  localparam int SEL_W = $clog2(N_SRC)
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_flush,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [N_SRC*DATA_W-1:0] i_src_data,
  input  logic [SEL_W-1:0]        i_wb_selector,
  input  logic                    i_write_back,
  input  logic [ADDR_W-1:0]       i_write_addr,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [DATA_W-1:0]       o_wb_data,
  output logic [SEL_W-1:0]        o_wb_selector,
  output logic [ADDR_W-1:0]       o_write_addr,
  output logic                    o_write_back,
  output logic                    o_fwd_valid,
  output logic [ADDR_W-1:0]       o_fwd_addr,
  output logic [DATA_W-1:0]       o_fwd_data
);

  logic                    head_v_q,    head_v_d;
  logic [N_SRC*DATA_W-1:0] head_src_q,  head_src_d;
  logic [SEL_W-1:0]        head_sel_q,  head_sel_d;
  logic                    head_wb_q,   head_wb_d;
  logic [ADDR_W-1:0]       head_addr_q, head_addr_d;

  logic                    skid_v_q,    skid_v_d;
  logic [N_SRC*DATA_W-1:0] skid_src_q,  skid_src_d;
  logic [SEL_W-1:0]        skid_sel_q,  skid_sel_d;
  logic                    skid_wb_q,   skid_wb_d;
  logic [ADDR_W-1:0]       skid_addr_q, skid_addr_d;

  logic accept;
  logic drain;

  // Next-state for head/skid occupancy and payload; flush squashes everything.
  always_comb begin
    accept      = i_valid & ~skid_v_q;
    drain       = head_v_q & i_ready;

    head_v_d    = head_v_q;
    head_src_d  = head_src_q;
    head_sel_d  = head_sel_q;
    head_wb_d   = head_wb_q;
    head_addr_d = head_addr_q;
    skid_v_d    = skid_v_q;
    skid_src_d  = skid_src_q;
    skid_sel_d  = skid_sel_q;
    skid_wb_d   = skid_wb_q;
    skid_addr_d = skid_addr_q;

    case ({head_v_q, skid_v_q})
      WB_EMPTY: begin
        if (accept) begin
          head_v_d    = 1'b1;
          head_src_d  = i_src_data;
          head_sel_d  = i_wb_selector;
          head_wb_d   = i_write_back;
          head_addr_d = i_write_addr;
        end
      end
      WB_ONE: begin
        if (accept && drain) begin
          head_src_d  = i_src_data;
          head_sel_d  = i_wb_selector;
          head_wb_d   = i_write_back;
          head_addr_d = i_write_addr;
        end else if (accept) begin
          skid_v_d    = 1'b1;
          skid_src_d  = i_src_data;
          skid_sel_d  = i_wb_selector;
          skid_wb_d   = i_write_back;
          skid_addr_d = i_write_addr;
        end else if (drain) begin
          head_v_d    = 1'b0;
        end
      end
      WB_TWO: begin
        if (drain) begin
          head_src_d  = skid_src_q;
          head_sel_d  = skid_sel_q;
          head_wb_d   = skid_wb_q;
          head_addr_d = skid_addr_q;
          skid_v_d    = 1'b0;
        end
      end
      default: begin
        // Unreachable skid-only state: recover to empty.
        head_v_d = 1'b0;
        skid_v_d = 1'b0;
      end
    endcase

    if (i_flush) begin
      head_v_d  = 1'b0;
      skid_v_d  = 1'b0;
      head_wb_d = 1'b0;
      skid_wb_d = 1'b0;
    end
  end

  // State registers; reset zeroes every stored field.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      head_v_q    <= 1'b0;
      head_src_q  <= '0;
      head_sel_q  <= '0;
      head_wb_q   <= 1'b0;
      head_addr_q <= '0;
      skid_v_q    <= 1'b0;
      skid_src_q  <= '0;
      skid_sel_q  <= '0;
      skid_wb_q   <= 1'b0;
      skid_addr_q <= '0;
    end else begin
      head_v_q    <= head_v_d;
      head_src_q  <= head_src_d;
      head_sel_q  <= head_sel_d;
      head_wb_q   <= head_wb_d;
      head_addr_q <= head_addr_d;
      skid_v_q    <= skid_v_d;
      skid_src_q  <= skid_src_d;
      skid_sel_q  <= skid_sel_d;
      skid_wb_q   <= skid_wb_d;
      skid_addr_q <= skid_addr_d;
    end
  end

  wb_src_mux #(
    .N_SRC  (N_SRC),
    .DATA_W (DATA_W)
  ) u_mux (
    .src_dat (head_src_q),
    .sel     (head_sel_q),
    .wb_dat  (o_wb_data)
  );

  assign o_ready       = ~skid_v_q;
  assign o_valid       = head_v_q;
  assign o_wb_selector = head_sel_q;
  assign o_write_addr  = head_addr_q;
  // Bubbles never write the register file.
  assign o_write_back  = head_v_q & head_wb_q;
  assign o_fwd_valid   = o_write_back;
  assign o_fwd_addr    = head_addr_q;
  assign o_fwd_data    = o_wb_data;

endmodule

// File: doc/wb_stage_skid_buffer.md
Name: wb_stage_skid_buffer

Overview:
Parametrised successor to the EX/MEM→WB pipeline register. It registers N_SRC candidate write-back sources (ALU result, memory data, immediate, port, …) plus selector, write-enable and destination address. It adds valid/ready handshaking, a 2-entry skid so back-pressure never drops data, a flush input for squashing, and a write-back data mux with a forwarding tap. It sits between the execute/memory stage and the register-file write port.

Parameters:
DATA_W, 16, width of each source and of the write-back data
ADDR_W, 3, register-file address width
N_SRC, 4, number of write-back sources (≥2)
SEL_W (localparam), $clog2(N_SRC), selector width

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  synchronous, active-high reset
i_flush  in  1  synchronous squash of all held entries
i_valid  in  1  upstream entry valid
o_ready  out  1  buffer can accept an entry this cycle
i_src_data  in  N_SRC*DATA_W  packed sources; source k at bits [k*DATA_W +: DATA_W]
i_wb_selector  in  SEL_W  source index
i_write_back  in  1  entry writes the register file
i_write_addr  in  ADDR_W  destination register
o_valid  out  1  head entry valid
i_ready  in  1  downstream accepts head entry
o_wb_data  out  DATA_W  head source selected by head selector
o_wb_selector  out  SEL_W  head selector
o_write_addr  out  ADDR_W  head destination
o_write_back  out  1  head write enable, qualified: head_valid & head_wb
o_fwd_valid  out  1  equals o_write_back, for hazard forwarding
o_fwd_addr  out  ADDR_W  equals o_write_addr
o_fwd_data  out  DATA_W  equals o_wb_data

Behaviour:
- Clock i_clk. Reset i_reset is synchronous, active-high. It is sampled on the rising edge and clears all state.
- Storage: head register and skid register. Each holds sources, selector, write_back, address and a valid bit.
- States from {head_v, skid_v}: EMPTY (0,0), ONE (1,0), TWO (1,1). (0,1) is illegal and never reached.
- o_ready = !skid_v. It depends only on registered state, with no combinational path from i_ready.
- o_valid = head_v. Accept = i_valid & o_ready. Drain = head_v & i_ready.
- EMPTY: on accept → ONE, entry loaded into head.
- ONE:
  - accept & drain → ONE, head replaced by new entry.
  - accept & !drain → TWO, new entry into skid.
  - !accept & drain → EMPTY.
  - Otherwise hold.
- TWO: o_ready=0.
  - On drain → ONE, skid moves to head, skid_v cleared.
  - Otherwise hold.
- Latency: an entry accepted at edge N is visible on outputs after edge N (1 cycle). Full throughput of 1/cycle when i_ready is held high.
- Priority: reset > flush > normal. Flush clears head_v, skid_v and both stored write_back bits. Any entry offered in the flush cycle is discarded, even if i_valid & o_ready.
- Reset values: o_valid=0, o_ready=1, o_wb_data=0, o_wb_selector=0, o_write_addr=0, o_write_back=0, fwd outputs=0. All stored data is zeroed.
- Reset or flush mid-operation (state TWO) → EMPTY next cycle. o_ready=1 in that next cycle.
- Outputs are stable while o_valid & !i_ready; stored fields do not change unless a transition occurs.
- o_wb_data mux is combinational from head registers. A selector ≥ N_SRC yields all zeros.
- o_write_back is forced 0 whenever head_v=0, so bubbles never write.
- Data fields of invalid entries are don't-care, except that they reset to 0.
- i_valid=0 with i_ready=1 is legal; the state drains normally.

Decomposition:
- Shared package `wb_pkg`: DATA_W/ADDR_W defaults, source index constants (WB_SRC_ALU=0, WB_SRC_MEM=1, WB_SRC_IMM=2, WB_SRC_PORT=3), N_SRC default.
- One sub-module, `wb_src_mux` (N_SRC, DATA_W): packed sources + selector → data, zero on out-of-range. The top-level module holds the head/skid FSM and registers.

Test Plan:
- Reset then stream: i_ready=1; entries addr 1..4, sel=0, src0=0x1111,0x2222,0x3333,0x4444, wb=1 → o_valid from the cycle after first accept. Same order, one per cycle, o_ready stays 1.
- Back-pressure: i_ready=0, offer A (addr 2, data 0xAAAA) and B (addr 5, data 0xBBBB) → o_ready=0 after B. C offered next cycle is not accepted. Raise i_ready → A then B output; o_ready returns to 1 after A drains.
- Selector mux: src={0x0004,0x0003,0x0002,0x0001}, sel=0..3 → o_wb_data 0x0001,0x0002,0x0003,0x0004. With N_SRC=3 and sel=3 → 0x0000.
- Flush in TWO with i_valid=1 offering D → next cycle o_valid=0, o_write_back=0, o_ready=1, D never appears.
- Bubble: entry wb=1 addr 7 followed by i_valid=0 with i_ready=1 → o_write_back=1 one cycle, then 0. o_fwd_valid mirrors it.
- Reset mid-stream: i_reset=1 for one cycle while in ONE → all outputs at reset values next cycle. Subsequent accept works normally.
